seq_div_unit: RTL and testbench

//  Multi-cycle 16-bit integer divider, the inverse-operation partner of the

---
 rtl/seq_div_unit_if.sv | 25 ++
 rtl/seq_div_unit.sv | 174 +++++++++++++++++
 tb/tb_seq_div_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_div_unit_if.sv
// Request/response bundle between the EX stage and the sequential divider.
// The master drives the operands and start; the slave returns the status and the held results.
interface seq_div_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sign;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Quot;
  logic [WIDTH-1:0] Rem;
  logic             Ofl;

  modport master (
    output start, A, B, sign,
    input  busy, done, Quot, Rem, Ofl
  );

  modport slave (
    input  start, A, B, sign,
    output busy, done, Quot, Rem, Ofl
  );
endinterface

// File: rtl/seq_div_unit.sv
// Multi-cycle restoring shift-subtract divider, signed or unsigned, one quotient bit per clock.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterations.
module seq_div_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_div_unit_if.slave  bus
);

  localparam int unsigned      CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             ofl_q, ofl_d;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH:0]   trial;
  logic             div_zero;
  logic             sgn_ovf;

  // dvd_q shifts the dividend out at the top and collects quotient bits at the bottom.
  assign rem_sh   = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {1'b0, dsr_q};
  // Only meaningful in StPrep, while dsr_q still holds the raw divisor.
  assign div_zero = (dsr_q == '0);
  assign sgn_ovf  = sign_q && (a_q == MinNeg) && (dsr_q == '1);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    ofl_d   = ofl_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.A;
          dvd_d   = bus.A;
          dsr_d   = bus.B;
          sign_d  = bus.sign;
          state_d = StPrep;
        end
      end

      StPrep: begin
        dvd_d   = (sign_q && a_q[WIDTH-1]) ? -a_q : a_q;
        dsr_d   = (sign_q && dsr_q[WIDTH-1]) ? -dsr_q : dsr_q;
        rem_d   = '0;
        cnt_d   = CntLast;
        q_neg_d = sign_q & (a_q[WIDTH-1] ^ dsr_q[WIDTH-1]);
        r_neg_d = sign_q & a_q[WIDTH-1];
        dz_d    = div_zero;
        ov_d    = sgn_ovf;
        state_d = StIter;
`ifdef DIV_EARLY_OUT_EN
        if (div_zero || sgn_ovf) begin
          quot_d  = div_zero ? '1 : MinNeg;
          remo_d  = div_zero ? a_q : '0;
          ofl_d   = 1'b1;
          state_d = StDone;
        end
`else
        // Faults still run the full iteration; results are overridden in StFix.
`endif
      end

      StIter: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end

      StFix: begin
        if (dz_q) begin
          quot_d = '1;
          remo_d = a_q;
          ofl_d  = 1'b1;
        end else if (ov_q) begin
          quot_d = MinNeg;
          remo_d = '0;
          ofl_d  = 1'b1;
        end else begin
          quot_d = q_neg_q ? -dvd_q : dvd_q;
          remo_d = r_neg_q ? -rem_q : rem_q;
          ofl_d  = 1'b0;
        end
        state_d = StDone;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      ofl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      ofl_q   <= ofl_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.Quot = quot_q;
  assign bus.Rem  = remo_q;
  assign bus.Ofl  = ofl_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Bench for seq_div_unit: table vectors, corner sequences and random operations
// checked against an arithmetic reference model.
module tb_seq_div_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] prev_q = '0;
  logic [15:0] prev_r = '0;
  logic        prev_o = 1'b0;

  always #5 clk = ~clk;

  seq_div_unit_if #(.WIDTH(16)) bus ();

  seq_div_unit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] q;
    logic [15:0] r;
    logic        o;
  } vec_t;

  vec_t tbl[13];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endfunction

  // Reference: plain integer division with the documented fault results.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output logic [15:0] q, output logic [15:0] r, output logic o);
    int sa;
    int sb;
    o = 1'b0;
    if (b == 16'h0000) begin
      q = 16'hFFFF;
      r = a;
      o = 1'b1;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -32768 && sb == -1) begin
        q = 16'h8000;
        r = 16'h0000;
        o = 1'b1;
      end else begin
        q = 16'(sa / sb);
        r = 16'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic int exp_lat(input logic fault);
`ifdef DIV_EARLY_OUT_EN
    return fault ? 2 : 19;
`else
    return (fault === 1'bx) ? 0 : 19;
`endif
  endfunction

  // Cycle 1 is the one right after the accepting edge; n1/n2 inject ignored starts.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int n1, input int n2,
                        output logic [15:0] q, output logic [15:0] r, output logic o,
                        output int lat);
    int n;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    bus.A     = a;
    bus.B     = b;
    bus.sign  = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    n = 1;
    @(negedge clk);
    while (!bus.done && n < 40) begin
      if (n == 10) begin
        chk("held_quot", 32'(bus.Quot), 32'(prev_q));
        chk("held_rem", 32'(bus.Rem), 32'(prev_r));
      end
      bus.start = (n == n1 || n == n2);
      if (bus.start) begin
        bus.A    = 16'($urandom);
        bus.B    = 16'($urandom);
        bus.sign = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    chk("done_busy", 32'(bus.busy), 32'd1);
    q   = bus.Quot;
    r   = bus.Rem;
    o   = bus.Ofl;
    lat = bus.done ? n : -1;
  endtask

  task automatic do_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int n1, input int n2);
    logic [15:0] eq, er, gq, gr;
    logic        eo, go;
    int          lat;
    model(a, b, s, eq, er, eo);
    run_op(a, b, s, n1, n2, gq, gr, go, lat);
    chk({tag, "_quot"}, 32'(gq), 32'(eq));
    chk({tag, "_rem"}, 32'(gr), 32'(er));
    chk({tag, "_ofl"}, 32'(go), 32'(eo));
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat(eo)));
    prev_q = eq;
    prev_r = er;
    prev_o = eo;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [15:0] ra, rb;
    logic        rs;
    int          mode;

    tbl[0]  = '{16'd100,   16'd7,     1'b0, 16'd14,    16'd2,     1'b0};
    tbl[1]  = '{16'hFFF9,  16'h0002,  1'b1, 16'hFFFD,  16'hFFFF,  1'b0};
    tbl[2]  = '{16'h1234,  16'h0000,  1'b1, 16'hFFFF,  16'h1234,  1'b1};
    tbl[3]  = '{16'h1234,  16'h0000,  1'b0, 16'hFFFF,  16'h1234,  1'b1};
    tbl[4]  = '{16'h8000,  16'hFFFF,  1'b1, 16'h8000,  16'h0000,  1'b1};
    tbl[5]  = '{16'h8000,  16'hFFFF,  1'b0, 16'h0000,  16'h8000,  1'b0};
    tbl[6]  = '{16'h0007,  16'hFFFE,  1'b1, 16'hFFFD,  16'h0001,  1'b0};
    tbl[7]  = '{16'hFFF9,  16'hFFFE,  1'b1, 16'h0003,  16'hFFFF,  1'b0};
    tbl[8]  = '{16'hFFFF,  16'hFFFF,  1'b0, 16'h0001,  16'h0000,  1'b0};
    tbl[9]  = '{16'h0000,  16'h0005,  1'b1, 16'h0000,  16'h0000,  1'b0};
    tbl[10] = '{16'hFFFF,  16'h0001,  1'b1, 16'hFFFF,  16'h0000,  1'b0};
    tbl[11] = '{16'h8000,  16'h0001,  1'b1, 16'h8000,  16'h0000,  1'b0};
    tbl[12] = '{16'hFFFF,  16'h0000,  1'b1, 16'hFFFF,  16'hFFFF,  1'b1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.sign  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quot", 32'(bus.Quot), 32'd0);
    chk("rst_rem", 32'(bus.Rem), 32'd0);
    chk("rst_ofl", 32'(bus.Ofl), 32'd0);
    rst_n = 1'b1;

    // Table vectors: the model's results must agree with the hand-derived expectations.
    for (int i = 0; i < 13; i++) begin
      logic [15:0] mq, mr, gq, gr;
      logic        mo, go;
      int          lat;
      model(tbl[i].a, tbl[i].b, tbl[i].s, mq, mr, mo);
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, 0, 0, gq, gr, go, lat);
      chk($sformatf("tbl%0d_quot", i), 32'(gq), 32'(tbl[i].q));
      chk($sformatf("tbl%0d_rem", i), 32'(gr), 32'(tbl[i].r));
      chk($sformatf("tbl%0d_ofl", i), 32'(go), 32'(tbl[i].o));
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(exp_lat(tbl[i].o)));
      chk($sformatf("tbl%0d_model", i), {mq, mr}, {tbl[i].q, tbl[i].r});
      prev_q = tbl[i].q;
      prev_r = tbl[i].r;
      prev_o = tbl[i].o;
    end

    // Starts at cycles 5 and 18 of a busy op are ignored; cycle 20 start is accepted.
    do_vec("ignore_start", 16'd100, 16'd7, 1'b0, 5, 18);
    do_vec("back_to_back", 16'hFFF9, 16'h0002, 1'b1, 0, 0);

    // Asynchronous reset in cycle 8 of an operation.
    @(negedge clk);
    bus.A     = 16'hFFFF;
    bus.B     = 16'h0003;
    bus.sign  = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_quot", 32'(bus.Quot), 32'd0);
    chk("midrst_rem", 32'(bus.Rem), 32'd0);
    chk("midrst_ofl", 32'(bus.Ofl), 32'd0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
      if (i == 3) rst_n = 1'b1;
    end
    chk("midrst_no_done", 32'(pulses), 32'd0);
    chk("midrst_idle", 32'(bus.busy), 32'd0);
    prev_q = '0;
    prev_r = '0;
    prev_o = 1'b0;
    do_vec("after_rst", 16'd100, 16'd7, 1'b0, 0, 0);

    // Random operations, biased toward zero divisors, the overflow pair and small divisors.
    for (int i = 0; i < 200; i++) begin
      mode = int'($urandom_range(0, 9));
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rs   = 1'($urandom);
      if (mode == 0) begin
        rb = 16'h0000;
      end else if (mode == 1) begin
        ra = 16'h8000;
        rb = 16'hFFFF;
        rs = 1'b1;
      end else if (mode == 2) begin
        rb = 16'($urandom_range(1, 15));
      end else if (mode == 3) begin
        rb = -16'($urandom_range(1, 15));
      end
      do_vec($sformatf("rnd%0d", i), ra, rb, rs, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
